bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter. It is the inverse path of the project's binary-to-BCD display logic and turns packed BCD digits from ui_in/uio_in into a binary value. It uses a reverse double-dabble algorithm: one shift-and-correct iteration per clock, with a valid/ready handshake on both sides. It sits between the pad-input capture and the tt_um_BCD core datapath.

---
 rtl/bcd_to_bin_seq_if.sv | 29 ++
 rtl/bcd_to_bin_seq.sv | 122 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
//   Request side : in_valid, in_ready, bcd_in (packed BCD, digit 0 in [3:0])
//   Result side  : out_valid, out_ready, bin_out, err
//   Status       : busy
// The master modport is the producer/consumer around the converter; the
// slave modport is the converter itself.
interface bcd_to_bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One shift-and-correct iteration per clock; BIN_W iterations per request.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - bcd_to_bin_seq_if.slave: in_valid/in_ready/bcd_in request side,
//          out_valid/out_ready/bin_out/err result side, busy status.
// A request with any digit > 9 skips conversion and reports err=1, bin_out=0.
// bin_out/err are held from one result until the next result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic                   err_q, err_d;
  logic [SR_W-1:0]        shifted;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Undo the +3 of forward double-dabble: after a right shift a digit that
  // reached 8 or more carried in a half-weight bit of 8, which must be 5.
  function automatic logic [BCD_W-1:0] fix_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d >= 4'd8) d = d - 4'd3;
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // The BCD LSB falls into the binary MSB as the whole register shifts right.
  assign shifted = sr_q >> 1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (has_bad_digit(bus.bcd_in)) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        sr_d  = {fix_digits(shifted[SR_W-1:BIN_W]), shifted[BIN_W-1:0]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bin_d   = shifted[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // Status outputs depend only on registered state.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   chk_en;

  bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dec_value(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit any_bad(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  // Behavioural model: a request is idle / converting for BIN_W cycles /
  // holding its result; values come from decimal arithmetic.
  int m_mode  = 0;   // 0 idle, 1 converting, 2 result pending
  int m_left  = 0;
  int m_pend  = 0;
  int m_bin   = 0;
  int m_err   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0;
      m_left <= 0;
      m_bin  <= 0;
      m_err  <= 0;
    end else begin
      case (m_mode)
        0: if (bus.in_valid) begin
          if (any_bad(bus.bcd_in)) begin
            m_mode <= 2;
            m_bin  <= 0;
            m_err  <= 1;
          end else begin
            m_mode <= 1;
            m_left <= BIN_W;
            m_pend <= dec_value(bus.bcd_in);
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_mode <= 2;
            m_bin  <= m_pend;
            m_err  <= 0;
          end
        end
        default: if (bus.out_ready) m_mode <= 0;
      endcase
    end
  end

  always @(posedge clk) if (rst) chk_en <= 1'b1;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(bus.in_ready),  int'(m_mode == 0));
      check("out_valid", int'(bus.out_valid), int'(m_mode == 2));
      check("busy",      int'(bus.busy),      int'(m_mode != 0));
      check("bin_out",   int'(bus.bin_out),   m_bin);
      check("err",       int'(bus.err),       m_err);
    end
  end

  task automatic send(input logic [11:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = b;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", int'(n < 300), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp_bin, input int exp_err,
                             input int exp_lat, input int acc, input bit consume);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_time"}, int'(n < 300), 1);
    check({name, "_latency"}, cyc - acc, exp_lat);
    check({name, "_bin"}, int'(bus.bin_out), exp_bin);
    check({name, "_err"}, int'(bus.err), exp_err);
    if (consume) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rel;

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bcd_in    = 12'h123;
    bus.out_ready = 1'b0;

    // Reset held with a pending request: nothing is accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  int'(bus.in_ready),  1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_bin",       int'(bus.bin_out),   0);
    check("rst_err",       int'(bus.err),       0);
    check("rst_busy",      int'(bus.busy),      0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", int'(bus.busy), 0);

    // Basic conversions with hand-computed results.
    send(12'h999, acc); wait_result("b999", 999, 0, 10, acc, 1'b1);
    send(12'h000, acc); wait_result("b000",   0, 0, 10, acc, 1'b1);
    send(12'h100, acc); wait_result("b100", 100, 0, 10, acc, 1'b1);
    send(12'h255, acc); wait_result("b255", 255, 0, 10, acc, 1'b1);

    // Invalid digit: result is immediate, then a normal request clears err.
    send(12'h9A1, acc); wait_result("bad9A1", 0, 1, 0, acc, 1'b1);
    send(12'h001, acc); wait_result("b001",   1, 0, 10, acc, 1'b1);

    // Backpressure with a competing request waiting.
    send(12'h100, acc); wait_result("bp100", 100, 0, 10, acc, 1'b0);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h042;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready",  int'(bus.in_ready),  0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_bin",       int'(bus.bin_out),   100);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rel = cyc;
    bus.out_ready = 1'b0;
    send(12'h042, acc);
    check("bp_accept_next_edge", acc - rel, 1);
    wait_result("b042", 42, 0, 10, acc, 1'b1);

    // Reset in the middle of a conversion aborts it.
    send(12'h777, acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_reset_edge", cyc - acc, 4);
    repeat (15) begin
      @(negedge clk);
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_bin",       int'(bus.bin_out),   0);
    end
    send(12'h500, acc); wait_result("b500", 500, 0, 10, acc, 1'b1);

    // Sweep all values back-to-back with random consumer stalls.
    fork
      begin
        logic [11:0] b;
        int          a;
        for (int v = 0; v < 1000; v++) begin
          b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
          send(b, a);
        end
      end
      begin
        int n;
        for (int k = 0; k < 1000; k++) begin
          n = 0;
          @(negedge clk);
          while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
          end
          check("sweep_in_time", int'(n < 300), 1);
          check("sweep_bin", int'(bus.bin_out), k);
          check("sweep_err", int'(bus.err), 0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          bus.out_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.out_ready = 1'b0;
        end
      end
    join

    repeat (15) begin
      @(negedge clk);
      check("sweep_no_extra", int'(bus.out_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
